// File: rtl/btn_conditioner.sv
// Push-button conditioner: per-channel synchroniser, debounce FSM, press/release pulses
// and long-press detection. All outputs are registered.
module btn_conditioner #(
    parameter int unsigned N_BTN           = 3,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 100_000,
    parameter int unsigned LONG_CYCLES     = 10_000_000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic [N_BTN-1:0] btn_held
);

    localparam int unsigned CntW  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);

    localparam logic [CntW-1:0]  CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_CYCLES);
    localparam logic [HoldW-1:0] HoldFire = HoldW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        StReleased,
        StPressChk,
        StPressed,
        StReleaseChk
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q [N_BTN];
    logic [N_BTN-1:0]       s;

    state_e           state_q [N_BTN];
    state_e           state_d [N_BTN];
    logic [CntW-1:0]  cnt_q   [N_BTN];
    logic [CntW-1:0]  cnt_d   [N_BTN];
    logic [HoldW-1:0] hold_q  [N_BTN];
    logic [HoldW-1:0] hold_d  [N_BTN];

    logic [N_BTN-1:0] level_d, press_d, release_d, long_d, held_d;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                sync_q[i]  <= '0;
                state_q[i] <= StReleased;
                cnt_q[i]   <= '0;
                hold_q[i]  <= '0;
            end
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_long    <= '0;
            btn_held    <= '0;
        end else begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                sync_q[i]  <= {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                hold_q[i]  <= hold_d[i];
            end
            btn_level   <= level_d;
            btn_press   <= press_d;
            btn_release <= release_d;
            btn_long    <= long_d;
            btn_held    <= held_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_BTN; i++) begin
            s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    always_comb begin
        level_d   = '0;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        held_d    = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            hold_d[i]  = hold_q[i];

            // Hold time accumulates across release bounces and saturates.
            if ((state_q[i] == StPressed || state_q[i] == StReleaseChk) && hold_q[i] != HoldMax) begin
                hold_d[i] = hold_q[i] + HoldW'(1);
            end

            unique case (state_q[i])
                StReleased: begin
                    if (s[i]) begin
                        state_d[i] = StPressChk;
                        cnt_d[i]   = '0;
                    end
                end
                StPressChk: begin
                    if (!s[i]) begin
                        state_d[i] = StReleased;
                    end else if (cnt_q[i] == CntLast) begin
                        state_d[i] = StPressed;
                        hold_d[i]  = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntW'(1);
                    end
                end
                StPressed: begin
                    if (!s[i]) begin
                        state_d[i] = StReleaseChk;
                        cnt_d[i]   = '0;
                    end
                end
                StReleaseChk: begin
                    if (s[i]) begin
                        state_d[i] = StPressed;
                    end else if (cnt_q[i] == CntLast) begin
                        state_d[i] = StReleased;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntW'(1);
                    end
                end
                default: state_d[i] = StReleased;
            endcase

            level_d[i]   = (state_d[i] == StPressed) || (state_d[i] == StReleaseChk);
            press_d[i]   = level_d[i] & ~btn_level[i];
            release_d[i] = ~level_d[i] & btn_level[i];
            // Hold only climbs between clears, so the fire value is crossed once per press.
            long_d[i]    = (hold_d[i] == HoldFire) && (hold_q[i] != HoldFire);
            held_d[i]    = release_d[i] ? 1'b0 : (long_d[i] | btn_held[i]);
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
module tb_btn_conditioner;

    logic       clk_in = 1'b0;
    logic       rst;
    logic [2:0] btn_raw;
    logic [2:0] btn_level, btn_press, btn_release, btn_long, btn_held;

    int checks = 0;
    int errors = 0;

    btn_conditioner #(
        .N_BTN          (3),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (16)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long),
        .btn_held   (btn_held)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [2:0] raw;
        logic [2:0] level;
        logic [2:0] press;
        logic [2:0] rel;
        logic [2:0] lng;
        logic [2:0] held;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [2:0] raw, input logic [2:0] level,
                                input logic [2:0] press, input logic [2:0] rel);
        vec_t v;
        v.raw   = raw;
        v.level = level;
        v.press = press;
        v.rel   = rel;
        v.lng   = 3'b000;
        v.held  = 3'b000;
        vecs.push_back(v);
    endfunction

    task automatic chk1(input string name, input string sig, input logic [2:0] act,
                        input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s got %b want %b (t=%0t)", name, sig, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [2:0] level, input logic [2:0] press,
                           input logic [2:0] rel, input logic [2:0] lng, input logic [2:0] held);
        chk1(name, "level", btn_level, level);
        chk1(name, "press", btn_press, press);
        chk1(name, "release", btn_release, rel);
        chk1(name, "long", btn_long, lng);
        chk1(name, "held", btn_held, held);
    endtask

    // Raw changes on the falling edge; outputs sampled 1 ns after the next rising edge.
    task automatic tick(input logic [2:0] raw);
        @(negedge clk_in);
        btn_raw = raw;
        @(posedge clk_in);
        #1;
    endtask

    // Clean press then release on one channel: event appears on the 7th sampled edge.
    function automatic void add_press_release(input logic [2:0] m);
        for (int k = 1; k <= 8; k++) add(m, (k >= 7) ? m : 3'b000, (k == 7) ? m : 3'b000, 3'b000);
        for (int k = 1; k <= 8; k++) add(3'b000, (k < 7) ? m : 3'b000, 3'b000, (k == 7) ? m : 3'b000);
    endfunction

    initial begin
        add_press_release(3'b001);
        for (int k = 1; k <= 3; k++) add(3'b010, 3'b000, 3'b000, 3'b000);
        for (int k = 1; k <= 8; k++) add(3'b000, 3'b000, 3'b000, 3'b000);
        // Channel 1 must be back in RELEASED: next clean press keeps the nominal latency.
        add_press_release(3'b010);

        rst     = 1'b1;
        btn_raw = 3'b000;
        repeat (2) @(posedge clk_in);
        #1;
        chk_all("reset_state", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        rst = 1'b0;

        foreach (vecs[i]) begin
            tick(vecs[i].raw);
            chk_all($sformatf("vec%0d", i), vecs[i].level, vecs[i].press, vecs[i].rel,
                    vecs[i].lng, vecs[i].held);
        end

        // Long press on channel 2, held well past saturation.
        for (int k = 1; k <= 40; k++) begin
            tick(3'b100);
            chk_all($sformatf("long_k%0d", k), (k >= 7) ? 3'b100 : 3'b000,
                    (k == 7) ? 3'b100 : 3'b000, 3'b000, (k == 22) ? 3'b100 : 3'b000,
                    (k >= 22) ? 3'b100 : 3'b000);
        end

        // Release bounce: two low cycles then high again.
        for (int k = 1; k <= 14; k++) begin
            tick((k <= 2) ? 3'b000 : 3'b100);
            chk_all($sformatf("rbounce_k%0d", k), 3'b100, 3'b000, 3'b000, 3'b000, 3'b100);
        end

        for (int k = 1; k <= 8; k++) begin
            tick(3'b000);
            chk_all($sformatf("long_rel_k%0d", k), (k < 7) ? 3'b100 : 3'b000, 3'b000,
                    (k == 7) ? 3'b100 : 3'b000, 3'b000, (k < 7) ? 3'b100 : 3'b000);
        end

        // Simultaneous press and release on all channels.
        for (int k = 1; k <= 8; k++) begin
            tick(3'b111);
            chk_all($sformatf("simul_k%0d", k), (k >= 7) ? 3'b111 : 3'b000,
                    (k == 7) ? 3'b111 : 3'b000, 3'b000, 3'b000, 3'b000);
        end
        for (int k = 1; k <= 8; k++) begin
            tick(3'b000);
            chk_all($sformatf("simul_rel_k%0d", k), (k < 7) ? 3'b111 : 3'b000, 3'b000,
                    (k == 7) ? 3'b111 : 3'b000, 3'b000, 3'b000);
        end

        // Reset with channel 2 held long and channel 0 mid-debounce.
        for (int k = 1; k <= 24; k++) begin
            tick(3'b100);
            chk_all($sformatf("pre_rst_k%0d", k), (k >= 7) ? 3'b100 : 3'b000,
                    (k == 7) ? 3'b100 : 3'b000, 3'b000, (k == 22) ? 3'b100 : 3'b000,
                    (k >= 22) ? 3'b100 : 3'b000);
        end
        for (int k = 1; k <= 4; k++) begin
            tick(3'b101);
            chk_all($sformatf("pre_rst_chk_k%0d", k), 3'b100, 3'b000, 3'b000, 3'b000, 3'b100);
        end
        rst = 1'b1;
        #1;
        chk_all("rst_async", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        @(posedge clk_in);
        #1;
        chk_all("rst_held", 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        rst = 1'b0;

        // Buttons held through reset release act as a fresh press with a fresh hold count.
        for (int k = 1; k <= 24; k++) begin
            tick(3'b101);
            chk_all($sformatf("post_rst_k%0d", k), (k >= 7) ? 3'b101 : 3'b000,
                    (k == 7) ? 3'b101 : 3'b000, 3'b000, (k == 22) ? 3'b101 : 3'b000,
                    (k >= 22) ? 3'b101 : 3'b000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
